key_event_queue: RTL and testbench

Downstream consumer of the PS/2 `keyboard` receiver. It takes raw scan codes, parses make/break/extended prefixes and tracks held state for the three game keys (A, S, D). It queues press and release events in a small FIFO for the game controller. It replaces the `oneshot` read-pulse logic: this block generates `read` itself, once per scan code consumed.

---
 rtl/key_event_queue.sv | 139 +++++++++++++
 tb/tb_key_event_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_queue.sv
// PS/2 scan-code parser for the A/S/D game keys: tracks held state and queues
// press/release events in a small FIFO, generating the keyboard read pulse itself.
module key_event_queue #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [7:0] scan_code,
   input  logic       scan_ready,
   output logic       read,
   output logic       ev_valid,
   output logic [2:0] ev_data,
   input  logic       ev_ready,
   output logic [2:0] held,
   output logic       overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   localparam logic [7:0] CODE_BRK = 8'hF0;
   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_A   = 8'h1C;
   localparam logic [7:0] CODE_S   = 8'h1B;
   localparam logic [7:0] CODE_D   = 8'h23;

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

   state_t          state_q, state_d;
   logic            s1_q, s2_q, s3_q;
   logic [2:0]      held_q, held_d;
   logic            ovf_q, ovf_d;
   logic            read_q;
   logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [2:0]      mem_q [DEPTH];

   logic            strobe_c;
   logic [2:0]      key_oh_c;
   logic [1:0]      key_idx_c;
   logic            key_hit_c, key_held_c;
   logic            push_c, push_rel_c;
   logic            pop_c, full_c, wr_en_c, drop_c;

   assign strobe_c = s2_q & ~s3_q;

   // Map the three game keys to a one-hot held mask and an event key index
   always_comb begin
      key_oh_c  = '0;
      key_idx_c = '0;
      case (scan_code)
         CODE_A: begin key_oh_c = 3'b001; key_idx_c = 2'd0; end
         CODE_S: begin key_oh_c = 3'b010; key_idx_c = 2'd1; end
         CODE_D: begin key_oh_c = 3'b100; key_idx_c = 2'd2; end
         default: ;
      endcase
   end

   assign key_hit_c  = |key_oh_c;
   assign key_held_c = |(held_q & key_oh_c);

   // Prefix parser; held state follows key transitions even when the FIFO drops them
   always_comb begin
      state_d    = state_q;
      held_d     = held_q;
      push_c     = 1'b0;
      push_rel_c = 1'b0;
      if (strobe_c) begin
         case (state_q)
            IDLE: begin
               if (scan_code == CODE_BRK)      state_d = BRK;
               else if (scan_code == CODE_EXT) state_d = EXT;
               else if (key_hit_c && !key_held_c) begin
                  held_d = held_q | key_oh_c;
                  push_c = 1'b1;
               end
            end
            BRK: begin
               if (scan_code == CODE_BRK)      state_d = BRK;
               else if (scan_code == CODE_EXT) state_d = EXT;
               else begin
                  state_d = IDLE;
                  if (key_hit_c && key_held_c) begin
                     held_d     = held_q & ~key_oh_c;
                     push_c     = 1'b1;
                     push_rel_c = 1'b1;
                  end
               end
            end
            EXT: begin
               state_d = (scan_code == CODE_BRK) ? EXT_BRK : IDLE;
            end
            EXT_BRK: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign full_c  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign pop_c   = ev_valid & ev_ready;
   assign wr_en_c = push_c & (~full_c | pop_c);
   assign drop_c  = push_c & full_c & ~pop_c;
   assign wptr_d  = wptr_q + PW'(wr_en_c);
   assign rptr_d  = rptr_q + PW'(pop_c);
   assign ovf_d   = ovf_q | drop_c;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         state_q <= IDLE;
         held_q  <= '0;
         ovf_q   <= 1'b0;
         read_q  <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         s1_q    <= scan_ready;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         state_q <= state_d;
         held_q  <= held_d;
         ovf_q   <= ovf_d;
         read_q  <= strobe_c;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         if (wr_en_c) mem_q[wptr_q[AW-1:0]] <= {push_rel_c, key_idx_c};
      end
   end

   assign read     = read_q;
   assign held     = held_q;
   assign overflow = ovf_q;
   assign ev_valid = (wptr_q != rptr_q);
   assign ev_data  = mem_q[rptr_q[AW-1:0]];

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: a code-level event model checked every
// cycle, plus literal expectations for held state and drained event order.
module tb_key_event_queue;

   localparam int unsigned DEPTH = 4;

   logic       CLOCK_50;
   logic       resetn;
   logic [7:0] scan_code;
   logic       scan_ready;
   logic       read;
   logic       ev_valid;
   logic [2:0] ev_data;
   logic       ev_ready;
   logic [2:0] held;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   key_event_queue #(.DEPTH(DEPTH)) dut (
      .CLOCK_50  (CLOCK_50),
      .resetn    (resetn),
      .scan_code (scan_code),
      .scan_ready(scan_ready),
      .read      (read),
      .ev_valid  (ev_valid),
      .ev_data   (ev_data),
      .ev_ready  (ev_ready),
      .held      (held),
      .overflow  (overflow)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a code is consumed on the third edge that sees scan_ready high
   logic [2:0] m_q [$];
   logic [2:0] m_held = '0;
   logic       m_ovf  = 1'b0;
   logic       m_read = 1'b0;
   bit         m_ext  = 0;
   bit         m_brk  = 0;
   int         m_cnt  = 0;

   always @(posedge CLOCK_50 or negedge resetn) begin
      bit         pop, full, ev;
      logic [2:0] evd;
      int         k;
      if (!resetn) begin
         m_q.delete();
         m_held = '0; m_ovf = 1'b0; m_read = 1'b0;
         m_ext = 0; m_brk = 0; m_cnt = 0;
      end else begin
         full   = (m_q.size() == DEPTH);
         pop    = ev_ready && (m_q.size() > 0);
         ev     = 0;
         evd    = '0;
         m_read = 1'b0;
         m_cnt  = scan_ready ? ((m_cnt >= 4) ? 4 : m_cnt + 1) : 0;
         if (m_cnt == 3) begin
            m_read = 1'b1;
            if (scan_code == 8'hF0) begin
               if (m_ext && m_brk) begin m_ext = 0; m_brk = 0; end
               else m_brk = 1;
            end else if (scan_code == 8'hE0) begin
               if (m_ext) begin m_ext = 0; m_brk = 0; end
               else begin m_ext = 1; m_brk = 0; end
            end else begin
               k = (scan_code == 8'h1C) ? 0 : (scan_code == 8'h1B) ? 1 :
                   (scan_code == 8'h23) ? 2 : -1;
               if (!m_ext && k >= 0) begin
                  if (!m_brk && !m_held[k]) begin
                     m_held[k] = 1'b1; ev = 1; evd = {1'b0, 2'(k)};
                  end else if (m_brk && m_held[k]) begin
                     m_held[k] = 1'b0; ev = 1; evd = {1'b1, 2'(k)};
                  end
               end
               m_ext = 0; m_brk = 0;
            end
         end
         if (pop) void'(m_q.pop_front());
         if (ev) begin
            if (full && !pop) m_ovf = 1'b1;
            else m_q.push_back(evd);
         end
      end
   end

   always @(negedge CLOCK_50) begin
      chk("read", 8'(read), 8'(m_read));
      chk("held", 8'(held), 8'(m_held));
      chk("overflow", 8'(overflow), 8'(m_ovf));
      chk("ev_valid", 8'(ev_valid), 8'(m_q.size() != 0));
      if (m_q.size() != 0) chk("ev_data", 8'(ev_data), 8'(m_q[0]));
   end

   task automatic send(input logic [7:0] c, input bit pop_at_k2);
      @(negedge CLOCK_50); #1;
      scan_code  = c;
      scan_ready = 1'b1;
      @(posedge CLOCK_50);
      @(posedge CLOCK_50);
      if (pop_at_k2) begin @(negedge CLOCK_50); #1 ev_ready = 1'b1; end
      @(posedge CLOCK_50);
      #1 ev_ready = 1'b0;
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50); #1 scan_ready = 1'b0;
      repeat (3) @(posedge CLOCK_50);
   endtask

   // Expected entries packed 3 bits each, first-popped in the low bits
   task automatic drain(input string nm, input int n, input logic [11:0] e);
      int got = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge CLOCK_50); #1;
         if (!ev_valid) break;
         if (got < n) chk(nm, 8'(ev_data), 8'(e[3*got +: 3]));
         got++;
         ev_ready = 1'b1;
         @(posedge CLOCK_50); #1 ev_ready = 1'b0;
      end
      ev_ready = 1'b0;
      chk({nm, "_count"}, 8'(got), 8'(n));
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0; scan_ready = 1'b0; scan_code = '0; ev_ready = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      chk("rst_read", 8'(read), 8'd0);
      chk("rst_held", 8'(held), 8'd0);
      chk("rst_ovf", 8'(overflow), 8'd0);
      chk("rst_valid", 8'(ev_valid), 8'd0);
      chk("rst_data", 8'(ev_data), 8'd0);
      #1 resetn = 1'b1;

      // press A, then release A
      send(8'h1C, 0);
      chk("pressA_held", 8'(held), 8'b001);
      chk("pressA_valid", 8'(ev_valid), 8'd1);
      chk("pressA_data", 8'(ev_data), 8'b000);
      drain("d_pressA", 1, 12'o0000);
      chk("popA_valid", 8'(ev_valid), 8'd0);
      send(8'hF0, 0); send(8'h1C, 0);
      drain("d_relA", 1, 12'o0004);

      // press/release S; lone break prefix is silent
      send(8'h1B, 0);
      chk("pressS_held", 8'(held), 8'b010);
      send(8'hF0, 0);
      chk("brk_only_held", 8'(held), 8'b010);
      send(8'h1B, 0);
      chk("relS_held", 8'(held), 8'b000);
      drain("d_S", 2, 12'o0051);

      // typematic D, stray break of A
      send(8'h23, 0); send(8'h23, 0); send(8'h23, 0);
      send(8'hF0, 0); send(8'h1C, 0);
      chk("typ_held", 8'(held), 8'b100);
      drain("d_typ", 1, 12'o0002);

      // extended sequences are ignored and parser returns to idle
      send(8'hE0, 0); send(8'h1C, 0);
      send(8'hE0, 0); send(8'hF0, 0); send(8'h1C, 0);
      chk("ext_held", 8'(held), 8'b100);
      chk("ext_valid", 8'(ev_valid), 8'd0);
      send(8'h1C, 0);
      chk("post_ext_held", 8'(held), 8'b101);
      drain("d_ext", 1, 12'o0000);
      send(8'hF0, 0); send(8'h1C, 0);
      send(8'hF0, 0); send(8'h23, 0);
      drain("d_clear", 2, 12'o0064);

      // overflow: fifth event dropped, flag sticky
      send(8'h1C, 0); send(8'h1B, 0); send(8'h23, 0);
      send(8'hF0, 0); send(8'h1C, 0); send(8'h1C, 0);
      chk("ovf_flag", 8'(overflow), 8'd1);
      chk("ovf_held", 8'(held), 8'b111);
      drain("d_ovf", 4, 12'o4210);
      chk("ovf_sticky", 8'(overflow), 8'd1);

      // refill to full, then push and pop on the same edge
      send(8'hF0, 0); send(8'h1B, 0);
      send(8'hF0, 0); send(8'h23, 0);
      send(8'hF0, 0); send(8'h1C, 0);
      send(8'h1B, 0);
      chk("full_valid", 8'(ev_valid), 8'd1);
      send(8'h23, 1);
      chk("pushpop_held", 8'(held), 8'b110);
      chk("pushpop_ovf", 8'(overflow), 8'd1);
      drain("d_pushpop", 4, 12'o2146);

      // reset with an event queued and a break prefix pending
      send(8'h1C, 0); send(8'hF0, 0);
      @(negedge CLOCK_50); #1 resetn = 1'b0;
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      chk("mrst_valid", 8'(ev_valid), 8'd0);
      chk("mrst_data", 8'(ev_data), 8'd0);
      chk("mrst_held", 8'(held), 8'd0);
      chk("mrst_ovf", 8'(overflow), 8'd0);
      #1 resetn = 1'b1;
      send(8'h1C, 0);
      chk("after_rst_held", 8'(held), 8'b001);
      chk("after_rst_ovf", 8'(overflow), 8'd0);
      drain("d_after_rst", 1, 12'o0000);

      repeat (2) @(posedge CLOCK_50);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
